acum_ctrl: RTL and testbench
============================

Name: acum_ctrl

Overview:
- Sequencer for the GEMM accumulation buffer pair (accumulator FIFO plus output FIFO, each ROWS deep and 128 bits wide).
- Per job, counts systolic-array output rows over K tiles and drives the buffer controls:
  - valid/overwrite on tile 0;
  - valid only (accumulate) on middle tiles;
  - valid/store on the final tile.
- Then drains the output FIFO to the writeback path over a valid/ready handshake.
- Sits between the systolic-array output stage and the GEMM writeback/DMA unit.

Parameters:
- ROWS, 16, rows per tile; equals the accumulation buffer depth.
- KT_W, 8, width of the K-tile count field.
- DW, 128, packed output width (4 lanes x 32 bits).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  job request; sampled only in IDLE.
- k_tiles  in  KT_W  number of K tiles for the job; 0 is treated as 1.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last writeback handshake.
- sa_valid  in  1  a systolic-array output row is present this cycle.
- acc_valid  out  1  buffer valid.
- acc_store  out  1  buffer store.
- acc_overwrite  out  1  buffer overwrite.
- acc_rd_en  out  1  output FIFO read enable.
- acc_empty  in  1  output FIFO empty.
- acc_data  in  DW  output FIFO read data; valid the cycle after acc_rd_en.
- wb_valid  out  1  writeback data valid.
- wb_ready  in  1  writeback accepts data.
- wb_data  out  DW  registered writeback data.
- err  out  1  sticky; sa_valid was seen outside ACCUM. Cleared by reset or by an accepted start.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; wb_data 0.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - start=1 latches kt = max(k_tiles,1), clears row_cnt, tile_cnt and err, and moves to ACCUM next cycle.
  - start is ignored in every other state.
- ACCUM:
  - acc_valid = sa_valid (combinational).
  - acc_overwrite = (tile_cnt==0).
  - acc_store = (tile_cnt==kt-1).
  - Both are high together when kt==1.
  - overwrite and store are held stable for the whole tile.
  - Each sa_valid beat increments row_cnt.
  - At row_cnt==ROWS-1 with sa_valid: row_cnt wraps to 0 and tile_cnt increments.
  - On the last row of tile kt-1: go to DRAIN, drain_cnt = 0.
  - Gaps in sa_valid are allowed; counters hold during gaps.
- DRAIN:
  - Skid register holds wb_data/wb_valid.
  - acc_rd_en = !acc_empty && (drain_issued < ROWS) && (!wb_valid || wb_ready) && !rd_pending, where rd_pending means a read was issued last cycle and its data is not yet captured.
  - The cycle after acc_rd_en: wb_data <= acc_data, wb_valid <= 1.
  - wb_valid && wb_ready: wb_valid clears unless a new word lands that same cycle; drain_cnt increments.
  - Throughput is one word every 2 cycles minimum.
  - When drain_cnt reaches ROWS: go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Outside ACCUM:
  - acc_valid, acc_store and acc_overwrite are 0.
  - sa_valid sets err and is otherwise dropped.
- wb_valid stays high with wb_data stable until wb_ready is seen (AXI-stream rule).
- Mid-operation reset: immediate return to IDLE. The buffers share rst, so no partial state survives.
- acc_empty=1 in DRAIN: no read is issued; the block waits with no timeout.

Optional Feature:
- Macro ACUM_CTRL_PERF_EN adds:
  - output perf_stall (32 bits): counts DRAIN cycles with wb_valid=1 and wb_ready=0;
  - output perf_cycles (32 bits): counts busy cycles.
- Both counters clear on an accepted start and saturate at all ones.
- Without the macro, these ports and registers do not exist.

Decomposition:
- Gemm Config package holds:
  - typedef enum logic [1:0] acum_state_t {IDLE, ACCUM, DRAIN, DONE};
  - constants ACC_ROWS=16 and ACC_DW=128.
- One natural sub-module: acum_skid, a one-entry valid/ready output register holding wb_data/wb_valid. All other logic stays in acum_ctrl.

Test Plan:
- kt=1: start, 16 consecutive sa_valid -> all 16 beats have acc_overwrite=acc_store=1; DRAIN produces 16 wb beats; done pulses once; busy then drops.
- kt=3, sa_valid gaps every other cycle:
  - beats 0-15: overwrite=1, store=0;
  - beats 16-31: overwrite=0, store=0;
  - beats 32-47: store=1.
  - Pass condition: exactly 16 wb beats.
- DRAIN with wb_ready held low 10 cycles after the first wb_valid -> wb_data stable, no acc_rd_en issued while the skid is full, perf_stall=10 with ACUM_CTRL_PERF_EN defined.
- k_tiles=0 -> behaves identically to kt=1 (16 overwrite+store beats).
- sa_valid in IDLE, and start asserted during ACCUM -> err=1; the second start is ignored and tile/row counts are unaffected.
- rst low during DRAIN after 5 wb beats -> asynchronously busy=0, wb_valid=0, state IDLE; a new kt=1 job then completes normally.

Source files
------------

// File: rtl/acum_ctrl_pkg.sv
// Shared types and constants for the GEMM accumulation buffer sequencer.
package acum_ctrl_pkg;

  localparam int unsigned ACC_ROWS = 16;
  localparam int unsigned ACC_DW   = 128;
  localparam int unsigned ACC_KT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } acum_state_t;

  // Per-beat controls presented to the accumulator FIFO.
  typedef struct packed {
    logic valid;
    logic overwrite;
    logic store;
  } acc_ctl_t;

endpackage

// File: rtl/acum_ctrl_if.sv
// Job, systolic-array, accumulation-buffer and writeback signals of acum_ctrl.
interface acum_ctrl_if #(
  parameter int unsigned KT_W = 8,
  parameter int unsigned DW   = 128
);
  logic            start;
  logic [KT_W-1:0] k_tiles;
  logic            busy;
  logic            done;
  logic            sa_valid;
  logic            acc_valid;
  logic            acc_store;
  logic            acc_overwrite;
  logic            acc_rd_en;
  logic            acc_empty;
  logic [DW-1:0]   acc_data;
  logic            wb_valid;
  logic            wb_ready;
  logic [DW-1:0]   wb_data;
  logic            err;

  // Sequencer side
  modport slave (
    input  start, k_tiles, sa_valid, acc_empty, acc_data, wb_ready,
    output busy, done, acc_valid, acc_store, acc_overwrite, acc_rd_en,
           wb_valid, wb_data, err
  );

  // Environment side (array, buffers, writeback)
  modport master (
    output start, k_tiles, sa_valid, acc_empty, acc_data, wb_ready,
    input  busy, done, acc_valid, acc_store, acc_overwrite, acc_rd_en,
           wb_valid, wb_data, err
  );
endinterface

// File: rtl/acum_skid.sv
// One-entry valid/ready output register feeding the writeback path.
module acum_skid #(
  parameter int unsigned DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  // A load never coincides with a stalled entry: reads are only issued when the slot frees.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/acum_ctrl.sv
// Accumulation buffer sequencer: K-tile row counting, buffer controls and output drain.
// Optional ACUM_CTRL_PERF_EN adds perf_stall / perf_cycles saturating counters.
module acum_ctrl
  import acum_ctrl_pkg::*;
#(
  parameter int unsigned ROWS = ACC_ROWS,
  parameter int unsigned KT_W = ACC_KT_W,
  parameter int unsigned DW   = ACC_DW
) (
  input  logic        clk,
  input  logic        rst,
  acum_ctrl_if.slave  bus
`ifdef ACUM_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_cycles
`endif
);

  localparam int unsigned RW  = $clog2(ROWS);
  localparam int unsigned DCW = $clog2(ROWS + 1);

  acum_state_t     r_state;
  logic [KT_W-1:0] r_kt;
  logic [KT_W-1:0] r_tile_cnt;
  logic [RW-1:0]   r_row_cnt;
  logic [DCW-1:0]  r_drain_cnt;
  logic [DCW-1:0]  r_drain_issued;
  logic            r_rd_pending;
  logic            r_err;

  logic            w_in_accum;
  logic            w_start_acc;
  logic            w_last_row;
  logic            w_last_tile;
  logic            w_rd_en;
  logic            w_wb_valid;
  logic            w_wb_fire;
  logic [DW-1:0]   w_wb_data;
  acc_ctl_t        w_ctl;

  assign w_in_accum  = (r_state == ACCUM);
  assign w_start_acc = (r_state == IDLE) && bus.start;
  assign w_last_row  = (r_row_cnt == RW'(ROWS - 1));
  assign w_last_tile = (r_tile_cnt == (r_kt - KT_W'(1)));
  assign w_wb_fire   = w_wb_valid && bus.wb_ready;

  // Read only when the skid slot is free or freeing, and no read is still in flight.
  assign w_rd_en = (r_state == DRAIN) && !bus.acc_empty &&
                   (r_drain_issued < DCW'(ROWS)) &&
                   (!w_wb_valid || bus.wb_ready) && !r_rd_pending;

  assign w_ctl.valid     = w_in_accum && bus.sa_valid;
  assign w_ctl.overwrite = w_in_accum && (r_tile_cnt == '0);
  assign w_ctl.store     = w_in_accum && w_last_tile;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_kt           <= '0;
      r_tile_cnt     <= '0;
      r_row_cnt      <= '0;
      r_drain_cnt    <= '0;
      r_drain_issued <= '0;
      r_rd_pending   <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_rd_pending <= w_rd_en;

      // An accepted start clears the flag; a stray beat in that same cycle still counts.
      if (w_start_acc) begin
        r_err <= bus.sa_valid;
      end else if (bus.sa_valid && !w_in_accum) begin
        r_err <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_kt           <= (bus.k_tiles == '0) ? KT_W'(1) : bus.k_tiles;
            r_row_cnt      <= '0;
            r_tile_cnt     <= '0;
            r_drain_cnt    <= '0;
            r_drain_issued <= '0;
            r_state        <= ACCUM;
          end
        end
        ACCUM: begin
          if (bus.sa_valid) begin
            if (w_last_row) begin
              r_row_cnt  <= '0;
              r_tile_cnt <= r_tile_cnt + KT_W'(1);
              if (w_last_tile) begin
                r_drain_cnt    <= '0;
                r_drain_issued <= '0;
                r_state        <= DRAIN;
              end
            end else begin
              r_row_cnt <= r_row_cnt + RW'(1);
            end
          end
        end
        DRAIN: begin
          if (w_rd_en) begin
            r_drain_issued <= r_drain_issued + DCW'(1);
          end
          if (w_wb_fire) begin
            r_drain_cnt <= r_drain_cnt + DCW'(1);
            if (r_drain_cnt == DCW'(ROWS - 1)) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  acum_skid #(
    .DW (DW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (r_rd_pending),
    .i_data  (bus.acc_data),
    .i_ready (bus.wb_ready),
    .o_valid (w_wb_valid),
    .o_data  (w_wb_data)
  );

  assign bus.busy          = (r_state != IDLE);
  assign bus.done          = (r_state == DONE);
  assign bus.acc_valid     = w_ctl.valid;
  assign bus.acc_overwrite = w_ctl.overwrite;
  assign bus.acc_store     = w_ctl.store;
  assign bus.acc_rd_en     = w_rd_en;
  assign bus.wb_valid      = w_wb_valid;
  assign bus.wb_data       = w_wb_data;
  assign bus.err           = r_err;

`ifdef ACUM_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_cycles;

  // Saturating counters, restarted by each accepted job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_stall  <= '0;
      r_perf_cycles <= '0;
    end else if (w_start_acc) begin
      r_perf_stall  <= '0;
      r_perf_cycles <= '0;
    end else begin
      if ((r_state != IDLE) && (r_perf_cycles != '1)) begin
        r_perf_cycles <= r_perf_cycles + 32'd1;
      end
      if ((r_state == DRAIN) && w_wb_valid && !bus.wb_ready && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_stall  = r_perf_stall;
  assign perf_cycles = r_perf_cycles;
`endif

endmodule

// File: tb/tb_acum_ctrl.sv
// Scoreboard bench for acum_ctrl: directed jobs, expected beats/words queued at issue time.
module tb_acum_ctrl;

  localparam int unsigned ROWS   = 16;
  localparam int unsigned KT_W   = 8;
  localparam int unsigned DW     = 128;
  localparam int          ROWS_I = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  acum_ctrl_if #(.KT_W(KT_W), .DW(DW)) bus ();

`ifdef ACUM_CTRL_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_cycles;
`endif

  acum_ctrl #(
    .ROWS (ROWS),
    .KT_W (KT_W),
    .DW   (DW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus)
`ifdef ACUM_CTRL_PERF_EN
    ,
    .perf_stall  (perf_stall),
    .perf_cycles (perf_cycles)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int wb_cnt   = 0;
  int exp_seq  = 0;
  int st_seq   = 0;

  logic [1:0]    sb_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fifo_q[$];

  logic          f_push, f_rd;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  function automatic logic [DW-1:0] mkword(input int s);
    return {32'hA500_0000 | 32'(s), 32'(s * 3 + 1), ~32'(s), 32'(s) ^ 32'h5A5A_5A5A};
  endfunction

  task automatic check_i(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor: pops expectations whenever the DUT presents a beat or a writeback word.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.acc_valid) begin
        if (sb_q.size() == 0) begin
          flag("acc_beat", "acc_valid with no expected beat");
        end else begin
          logic [1:0] e;
          e = sb_q.pop_front();
          check_i("acc_overwrite", int'(bus.acc_overwrite), int'(e[1]));
          check_i("acc_store", int'(bus.acc_store), int'(e[0]));
        end
      end
      if (prev_hold) begin
        check_i("wb_hold_valid", int'(bus.wb_valid), 1);
        check_w("wb_hold_data", bus.wb_data, prev_data);
      end
      if (bus.wb_valid && !bus.wb_ready) check_i("rd_while_full", int'(bus.acc_rd_en), 0);
      if (bus.wb_valid && bus.wb_ready) begin
        wb_cnt++;
        if (exp_q.size() == 0) flag("wb_data", "writeback word with none expected");
        else check_w("wb_data", bus.wb_data, exp_q.pop_front());
      end
      if (bus.done) done_cnt++;
      prev_hold = bus.wb_valid && !bus.wb_ready;
      prev_data = bus.wb_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Buffer model: stored rows enter the output FIFO; reads return data the next cycle.
  initial begin
    bus.acc_empty = 1'b1;
    bus.acc_data  = '0;
    forever begin
      @(negedge clk);
      f_push = bus.acc_valid && bus.acc_store;
      f_rd   = bus.acc_rd_en;
      @(posedge clk);
      #1;
      if (!rst) begin
        fifo_q.delete();
      end else begin
        if (f_push) begin
          fifo_q.push_back(mkword(st_seq));
          st_seq++;
        end
        if (f_rd) begin
          if (fifo_q.size() == 0) flag("acc_rd_en", "read issued on empty FIFO");
          else bus.acc_data = fifo_q.pop_front();
        end
      end
      bus.acc_empty = (fifo_q.size() == 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_job(input int k, input bit gaps, input bit mid_start);
    int kte;
    kte = (k == 0) ? 1 : k;
    bus.k_tiles = KT_W'(k);
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    check_i("busy_after_start", int'(bus.busy), 1);
    for (int b = 0; b < kte * ROWS_I; b++) begin
      int  t;
      logic ov, st;
      t  = b / ROWS_I;
      ov = (t == 0);
      st = (t == kte - 1);
      sb_q.push_back({ov, st});
      if (st) begin
        exp_q.push_back(mkword(exp_seq));
        exp_seq++;
      end
      bus.sa_valid = 1'b1;
      if (mid_start && b == 5) begin
        bus.start   = 1'b1;
        bus.k_tiles = 8'd5;
      end
      tick();
      bus.sa_valid = 1'b0;
      bus.start    = 1'b0;
      if (gaps) tick();
    end
  endtask

  task automatic finish_job(input string name, input int d0, input int w0);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 1000);
    if (bus.busy) flag({name, "_timeout"}, "busy never dropped");
    #1;
    check_i({name, "_done"}, done_cnt - d0, 1);
    check_i({name, "_wb_beats"}, wb_cnt - w0, ROWS_I);
    check_i({name, "_exp_left"}, exp_q.size(), 0);
    check_i({name, "_beats_left"}, sb_q.size(), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0, n;
    bus.start    = 1'b0;
    bus.k_tiles  = '0;
    bus.sa_valid = 1'b0;
    bus.wb_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_i("rst_busy", int'(bus.busy), 0);
    check_i("rst_done", int'(bus.done), 0);
    check_i("rst_acc_valid", int'(bus.acc_valid), 0);
    check_i("rst_acc_store", int'(bus.acc_store), 0);
    check_i("rst_acc_overwrite", int'(bus.acc_overwrite), 0);
    check_i("rst_acc_rd_en", int'(bus.acc_rd_en), 0);
    check_i("rst_wb_valid", int'(bus.wb_valid), 0);
    check_w("rst_wb_data", bus.wb_data, '0);
    check_i("rst_err", int'(bus.err), 0);
    #2 rst = 1'b1;
    tick();

    // kt=1, back-to-back beats
    d0 = done_cnt; w0 = wb_cnt;
    issue_job(1, 1'b0, 1'b0);
    finish_job("kt1", d0, w0);
`ifdef ACUM_CTRL_PERF_EN
    check_i("kt1_perf_cycles", int'(perf_cycles), 50);
    check_i("kt1_perf_stall", int'(perf_stall), 0);
`endif

    // kt=3 with a gap after every beat
    d0 = done_cnt; w0 = wb_cnt;
    issue_job(3, 1'b1, 1'b0);
    finish_job("kt3_gaps", d0, w0);

    // k_tiles=0 treated as one tile
    d0 = done_cnt; w0 = wb_cnt;
    issue_job(0, 1'b0, 1'b0);
    finish_job("kt0", d0, w0);
`ifdef ACUM_CTRL_PERF_EN
    check_i("kt0_perf_cycles", int'(perf_cycles), 50);
`endif

    // Writeback back-pressure: ready low for the first 10 cycles of wb_valid
    d0 = done_cnt; w0 = wb_cnt;
    bus.wb_ready = 1'b0;
    issue_job(2, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wb_valid && n < 200);
    if (!bus.wb_valid) flag("stall_wait", "wb_valid never rose");
    repeat (10) @(posedge clk);
    #1 bus.wb_ready = 1'b1;
    finish_job("stall", d0, w0);
`ifdef ACUM_CTRL_PERF_EN
    check_i("stall_perf_stall", int'(perf_stall), 10);
`endif

    // Stray sa_valid in IDLE, ignored start in ACCUM, stray sa_valid in DRAIN
    bus.sa_valid = 1'b1;
    tick();
    bus.sa_valid = 1'b0;
    check_i("err_idle", int'(bus.err), 1);
    d0 = done_cnt; w0 = wb_cnt;
    issue_job(1, 1'b0, 1'b1);
    check_i("err_cleared_by_start", int'(bus.err), 0);
    bus.sa_valid = 1'b1;
    tick();
    bus.sa_valid = 1'b0;
    finish_job("mid_start", d0, w0);
    check_i("err_drain_sticky", int'(bus.err), 1);

    // Reset in the middle of the drain, then a clean job
    w0 = wb_cnt;
    issue_job(1, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((wb_cnt - w0) < 5 && n < 200);
    check_i("rst_mid_wb_beats", wb_cnt - w0, 5);
    #1 rst = 1'b0;
    sb_q.delete();
    exp_q.delete();
    #1;
    check_i("rst_mid_busy", int'(bus.busy), 0);
    check_i("rst_mid_wb_valid", int'(bus.wb_valid), 0);
    check_i("rst_mid_rd_en", int'(bus.acc_rd_en), 0);
    check_i("rst_mid_err", int'(bus.err), 0);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    tick();
    d0 = done_cnt; w0 = wb_cnt;
    issue_job(1, 1'b0, 1'b0);
    finish_job("after_rst", d0, w0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
